// File: rtl/dpb_stream_reader_pkg.sv
// Shared definitions for the DPB stream reader slice.
//   ADDR_W / DATA_W / LEN_W : RAM address, RAM/stream data and transfer length widths
//   MAX_LEN                 : largest legal transfer (one full sweep of the RAM)
//   rd_state_t              : reader FSM states
//   fifo_entry_t            : one buffered byte plus its end-of-transfer flag
package dpb_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = 13;
    localparam int MAX_LEN = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } fifo_entry_t;

endpackage

// File: rtl/dpb_stream_reader_if.sv
// Bus bundle between the stream reader, the block RAM read port and the byte consumer.
//   ram_ce/ram_oce/ram_wre/ram_ad : RAM port controls driven by the reader
//   ram_dout                      : RAM read data, valid one clock after ram_ce
//   m_valid/m_data/m_last         : byte stream driven by the reader
//   m_ready                       : consumer back-pressure
// master = the reader, slave = the RAM/consumer side.
interface dpb_stream_reader_if;
    import dpb_pkg::*;

    logic              ram_ce;
    logic              ram_oce;
    logic              ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [DATA_W-1:0] ram_dout;

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output ram_ce, ram_oce, ram_wre, ram_ad,
        input  ram_dout,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  ram_ce, ram_oce, ram_wre, ram_ad,
        output ram_dout,
        input  m_valid, m_data, m_last,
        output m_ready
    );

endinterface

// File: rtl/dpb_stream_reader_rd_fifo2.sv
// Two-entry synchronous FIFO that absorbs the registered RAM read latency.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : write wr_entry this cycle
//   pop         : drop the head entry this cycle
//   head        : oldest entry (zero after reset)
//   count       : number of stored entries (0..2)
//   full, empty : count == 2 / count == 0
module dpb_rd_fifo2
    import dpb_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic        pop,
    input  fifo_entry_t wr_entry,
    output fifo_entry_t head,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty
);

    fifo_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    // Storage is cleared too so that the stream outputs read zero out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // The reader never issues a read that would land on a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !(push && full));

endmodule

// File: rtl/dpb_stream_reader.sv
// Read-side master for the 4096x8 dual-port block RAM. A start command sweeps
// len bytes from base_addr (wrapping) out of the RAM and delivers them in
// ascending address order as a valid/ready byte stream, 1 byte/clk when the
// consumer never stalls.
//   clk, resetn     : clock (shared with the RAM port), asynchronous active-low reset
//   start           : command strobe, ignored while busy
//   base_addr, len  : transfer parameters, sampled on an accepted start
//   busy            : high from accepted start until the cycle done pulses
//   done            : one-cycle end-of-transfer pulse
//   bus (master)    : RAM read port and output byte stream
module dpb_stream_reader
    import dpb_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    dpb_stream_reader_if.master bus
);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q;

    logic              accept;
    logic              issue;
    logic              pop;
    logic              last_pop;
    logic              last_issue;
    logic [1:0]        occ;

    fifo_entry_t       wr_entry;
    fifo_entry_t       head;
    logic [1:0]        count;
    logic              full;
    logic              empty;

    dpb_rd_fifo2 u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (inflight_q),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // A read issued last cycle returns this cycle and is pushed with its last flag.
    assign wr_entry   = '{data: bus.ram_dout, last: inflight_last_q};
    assign pop        = !empty && bus.m_ready;
    assign last_pop   = pop && head.last;
    // Occupancy counts bytes already buffered plus the one still inside the RAM.
    assign occ        = count + {1'b0, inflight_q};
    assign accept     = (state_q == IDLE) && start;
    assign last_issue = issue && (remain_q == LEN_W'(1));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = READ;
                end
            end
            READ: begin
                // With two bytes committed a read is only safe if one leaves this cycle.
                issue = (occ < 2'd2) || ((occ == 2'd2) && pop);
                if (issue && (remain_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            // A zero-length command completes without touching the RAM.
            done_q          <= (accept && (len == '0)) || ((state_q == DRAIN) && last_pop);
            if (accept) begin
                addr_q   <= base_addr;
                remain_q <= len;
            end else if (issue) begin
                addr_q   <= addr_q + ADDR_W'(1);
                remain_q <= remain_q - LEN_W'(1);
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign bus.ram_ce  = issue;
    assign bus.ram_oce = 1'b1;
    assign bus.ram_wre = 1'b0;
    assign bus.ram_ad  = addr_q;
    assign bus.m_valid = !empty;
    assign bus.m_data  = head.data;
    assign bus.m_last  = head.last;

    a_len_range: assert property (@(posedge clk) disable iff (!resetn)
        accept |-> (len <= LEN_W'(MAX_LEN)));

endmodule

// File: tb/tb_dpb_stream_reader.sv
// Bench for dpb_stream_reader: a RAM model, a transaction-level reference
// (expected address and byte queues built per accepted command) checked on
// every falling edge, plus directed tests with literal expectations.
module tb_dpb_stream_reader;
    import dpb_pkg::*;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;

    dpb_stream_reader_if bus ();

    dpb_stream_reader dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Block RAM model: registered read, RAM[i] = i[7:0].
    logic [DATA_W-1:0] ram [MAX_LEN];
    initial begin
        for (int i = 0; i < MAX_LEN; i++) ram[i] = DATA_W'(i);
        bus.ram_dout = '0;
    end
    always @(posedge clk) if (bus.ram_ce) bus.ram_dout <= ram[bus.ram_ad];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state and logs
    int          exp_addr [$];
    logic [8:0]  exp_byte [$];
    int          got [$];
    int          lastq [$];
    int          ce_log [$];
    int          ce_count;
    int          read_cnt [MAX_LEN];
    int          outstanding;
    bit          mbusy;
    bit          exp_done;

    always @(negedge clk) begin
        logic [8:0] e;
        bit         hs;
        bit         nbusy;
        bit         ndone;
        int         a;
        if (!resetn) begin
            exp_addr.delete();
            exp_byte.delete();
            outstanding = 0;
            mbusy       = 1'b0;
            exp_done    = 1'b0;
        end else begin
            chk("busy", busy, mbusy);
            chk("done", done, exp_done);
            chk("ram_oce", bus.ram_oce, 1);
            chk("ram_wre", bus.ram_wre, 0);
            hs    = bus.m_valid && bus.m_ready;
            nbusy = mbusy;
            ndone = 1'b0;
            chk("ram_ce_extra", bus.ram_ce && (exp_addr.size() == 0), 0);
            chk("stream_extra", hs && (exp_byte.size() == 0), 0);
            if (bus.ram_ce) begin
                ce_count++;
                ce_log.push_back(int'(bus.ram_ad));
                read_cnt[bus.ram_ad]++;
                chk("read_while_full", (outstanding >= 2) && !hs, 0);
                if (exp_addr.size() != 0) chk("ram_ad", bus.ram_ad, exp_addr.pop_front());
            end
            if (hs) begin
                got.push_back(int'(bus.m_data));
                lastq.push_back(int'(bus.m_last));
                if (exp_byte.size() != 0) begin
                    e = exp_byte.pop_front();
                    chk("m_data", bus.m_data, e[8:1]);
                    chk("m_last", bus.m_last, e[0]);
                    if (e[0]) begin
                        nbusy = 1'b0;
                        ndone = 1'b1;
                    end
                end
            end
            outstanding += int'(bus.ram_ce) - int'(hs);
            if (start && !mbusy) begin
                if (len == '0) begin
                    ndone = 1'b1;
                end else begin
                    nbusy = 1'b1;
                    for (int i = 0; i < int'(len); i++) begin
                        a = (int'(base_addr) + i) % MAX_LEN;
                        exp_addr.push_back(a);
                        exp_byte.push_back({ram[a], 1'(i == int'(len) - 1)});
                    end
                end
            end
            mbusy    = nbusy;
            exp_done = ndone;
        end
    end

    task automatic clear_logs();
        got.delete();
        lastq.delete();
        ce_log.delete();
        ce_count = 0;
        for (int i = 0; i < MAX_LEN; i++) read_cnt[i] = 0;
    endtask

    // Returns one clock after the accepting edge, start already dropped.
    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // ncyc/first_v are counted in clock edges after the accepting edge.
    task automatic run_until_done(input int mode, input int budget, input bit inject,
                                  output int first_v, output int ncyc);
        int pat [4] = '{1, 0, 0, 1};
        first_v = -1;
        ncyc    = -1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (inject) begin
                start = (c == 100);
                if (c == 100) begin
                    base_addr = 12'h5A5;
                    len       = 13'd5;
                end
            end
            if (mode == 1) bus.m_ready = pat[(c + 1) % 4][0];
            if (bus.m_valid && first_v < 0) first_v = c + 1;
            if (done) begin
                ncyc = c + 1;
                break;
            end
        end
        if (ncyc < 0) chk("timeout_done", done, 1);
        start       = 1'b0;
        bus.m_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv;
        int nc;
        int bad;
        int t1d [4] = '{16, 17, 18, 19};
        int t1l [4] = '{0, 0, 0, 1};
        int t2a [4] = '{4094, 4095, 0, 1};
        int t2d [4] = '{254, 255, 0, 1};
        int t6d [3] = '{32, 33, 34};

        resetn      = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        len         = '0;
        bus.m_ready = 1'b1;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_ce", bus.ram_ce, 0);
        chk("rst_ram_ad", bus.ram_ad, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_last", bus.m_last, 0);
        resetn = 1'b1;

        // Test 1: base 0x010, len 4, no back-pressure
        clear_logs();
        do_start(12'h010, 13'd4);
        run_until_done(0, 100, 1'b0, fv, nc);
        chk("t1_first_valid", fv, 2);
        chk("t1_done_cycle", nc, 6);
        chk("t1_ce_count", ce_count, 4);
        chk("t1_nbytes", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("t1_data", got[i], t1d[i]);
            chk("t1_last", lastq[i], t1l[i]);
        end

        // Test 2: address wrap
        clear_logs();
        do_start(12'd4094, 13'd4);
        run_until_done(0, 100, 1'b0, fv, nc);
        chk("t2_ce_count", ce_count, 4);
        for (int i = 0; i < 4 && i < ce_log.size(); i++) chk("t2_addr", ce_log[i], t2a[i]);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_data", got[i], t2d[i]);

        // Test 3: m_ready pattern 1,0,0,1
        clear_logs();
        do_start(12'h040, 13'd8);
        run_until_done(1, 200, 1'b0, fv, nc);
        chk("t3_nbytes", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("t3_data", got[i], 32'h40 + 32'(i));

        // Test 4: zero-length command
        clear_logs();
        do_start(12'h123, 13'd0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_ram_ce", bus.ram_ce, 0);
        @(posedge clk); #1;
        chk("t4_done_after", done, 0);
        chk("t4_busy_after", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_ce_count", ce_count, 0);

        // Test 5: full-size sweep with an ignored start mid-transfer
        clear_logs();
        do_start(12'h800, 13'd4096);
        run_until_done(0, 5000, 1'b1, fv, nc);
        chk("t5_first_valid", fv, 2);
        chk("t5_done_cycle", nc, 4098);
        chk("t5_ce_count", ce_count, 4096);
        chk("t5_nbytes", got.size(), 4096);
        bad = 0;
        for (int i = 0; i < MAX_LEN; i++) if (read_cnt[i] != 1) bad++;
        chk("t5_addr_once", bad, 0);
        if (got.size() == 4096) begin
            chk("t5_first_byte", got[0], 32'h00);
            chk("t5_last_byte", got[4095], 32'hFF);
        end

        // Test 6: reset at the third byte of a len 16 transfer
        clear_logs();
        do_start(12'h100, 13'd16);
        for (int c = 0; c < 50; c++) begin
            if (got.size() >= 2) break;
            @(posedge clk); #1;
        end
        chk("t6_two_bytes", got.size(), 2);
        resetn = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_ram_ce", bus.ram_ce, 0);
        chk("t6_ram_ad", bus.ram_ad, 0);
        chk("t6_m_valid", bus.m_valid, 0);
        chk("t6_m_data", bus.m_data, 0);
        chk("t6_m_last", bus.m_last, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("t6_no_done_rst", done, 0);
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("t6_no_done_rel", done, 0);
        end
        clear_logs();
        do_start(12'h020, 13'd3);
        run_until_done(0, 100, 1'b0, fv, nc);
        chk("t6_done_cycle", nc, 5);
        chk("t6_nbytes", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("t6_data", got[i], t6d[i]);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
